// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// mips_ctrl_pkg : opcodes, state encodings and control-word codes for the
//                 multi-cycle MIPS control unit.   Rev 1.0
// ============================================================================
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    ST_RST       = 4'd0,
    ST_FETCH     = 4'd1,
    ST_DECODE    = 4'd2,
    ST_MEM_ADDR  = 4'd3,
    ST_MEM_READ  = 4'd4,
    ST_MEM_WB    = 4'd5,
    ST_MEM_WRITE = 4'd6,
    ST_EXECUTE   = 4'd7,
    ST_R_WB      = 4'd8,
    ST_BRANCH    = 4'd9,
    ST_JUMP      = 4'd10,
    ST_ADDI_EX   = 4'd11,
    ST_ADDI_WB   = 4'd12
  } estado_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_4       = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_fim;
    logic       illegal_op;
  } ctrl_word_t;

  function automatic logic op_suportado(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
  endfunction

endpackage
`default_nettype wire

// File: rtl/decod_saidas_ctrl.sv
`default_nettype none
// ============================================================================
// decod_saidas_ctrl : maps the registered state (plus mem_ready / opcode where
//                     allowed) to the datapath control word.   Rev 1.0
// ============================================================================
module decod_saidas_ctrl
  import mips_ctrl_pkg::*;
(
  input  estado_t    estado_i,
  input  logic       mem_ready_i,
  input  logic [5:0] opcode_i,
  output ctrl_word_t ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (estado_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_4;
        ctrl_o.alu_op    = ALUOP_ADD;
        ctrl_o.pc_source = PCSRC_ALU;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b  = SRCB_IMM_SH2;
        ctrl_o.alu_op     = ALUOP_ADD;
        ctrl_o.illegal_op = ~op_suportado(opcode_i);
      end
      ST_MEM_ADDR, ST_ADDI_EX: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.alu_op    = ALUOP_ADD;
      end
      ST_MEM_READ: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      ST_MEM_WRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.instr_fim = mem_ready_i;
      end
      ST_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.instr_fim  = 1'b1;
      end
      ST_EXECUTE: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_B;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.instr_fim = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.instr_fim = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_src_b     = SRCB_B;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.instr_fim     = 1'b1;
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.instr_fim = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/controle_multiciclo_mips.sv
`default_nettype none
// ============================================================================
// controle_multiciclo_mips : Moore FSM sequencing the shared multi-cycle MIPS
//                            datapath, with memory wait-state handshake. Rev 1.0
// ============================================================================
module controle_multiciclo_mips
  import mips_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_fim,
  output logic       illegal_op,
  output logic [3:0] estado
);

  estado_t    state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_word_t ctrl;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_RST:    state_d = ST_FETCH;
      ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = opcode;
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_RTYPE:     state_d = ST_EXECUTE;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
          default:      state_d = ST_FETCH;
        endcase
      end
      // The live opcode may already belong to the next fetch; trust op_q only.
      ST_MEM_ADDR:  state_d = (op_q == OP_SW) ? ST_MEM_WRITE : ST_MEM_READ;
      ST_MEM_READ:  if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WRITE: if (mem_ready) state_d = ST_FETCH;
      ST_EXECUTE:   state_d = ST_R_WB;
      ST_ADDI_EX:   state_d = ST_ADDI_WB;
      default:      state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RST;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  decod_saidas_ctrl u_decod (
    .estado_i    (state_q),
    .mem_ready_i (mem_ready),
    .opcode_i    (opcode),
    .ctrl_o      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign instr_fim     = ctrl.instr_fim;
  assign illegal_op    = ctrl.illegal_op;
  assign estado        = state_q;

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo_mips.sv
`default_nettype none
// ============================================================================
// tb_controle_multiciclo_mips : scoreboard bench, instruction-level model of
//                               the multi-cycle control sequence.   Rev 1.0
// ============================================================================
module tb_controle_multiciclo_mips;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, instr_fim, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] estado;

  controle_multiciclo_mips dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .instr_fim(instr_fim), .illegal_op(illegal_op),
    .estado(estado)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_fim, illegal_op;
  } obs_t;

  obs_t       exp_q[$];
  obs_t       mon_e, mon_a;
  int         checks = 0;
  int         passed = 0;
  int         cyc = 0;
  logic [5:0] legal_ops [6] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};

  function automatic bit is_legal(logic [5:0] op);
    for (int i = 0; i < 6; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Control word the datapath must see in a given step of an instruction.
  function automatic obs_t model(estado_t st, logic mr, logic [5:0] op);
    obs_t e;
    e = '0;
    e.st = st;
    case (st)
      ST_FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = mr; e.pc_write = mr; end
      ST_DECODE:    begin e.alu_src_b = 2'b11; e.illegal_op = !is_legal(op); end
      ST_MEM_ADDR,
      ST_ADDI_EX:   begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      ST_MEM_READ:  begin e.mem_read = 1; e.i_or_d = 1; end
      ST_MEM_WRITE: begin e.mem_write = 1; e.i_or_d = 1; e.instr_fim = mr; end
      ST_MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; e.instr_fim = 1; end
      ST_EXECUTE:   begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      ST_R_WB:      begin e.reg_write = 1; e.reg_dst = 1; e.instr_fim = 1; end
      ST_ADDI_WB:   begin e.reg_write = 1; e.instr_fim = 1; end
      ST_BRANCH:    begin e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_write_cond = 1;
                          e.pc_source = 2'b01; e.instr_fim = 1; end
      ST_JUMP:      begin e.pc_write = 1; e.pc_source = 2'b10; e.instr_fim = 1; end
      default:      e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom);
  endfunction

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  // st is the state expected after the edge just passed; rst/mr/op are driven now.
  task automatic step(estado_t st, logic rst, logic mr, logic [5:0] op);
    @(posedge clk);
    #1;
    reset     = rst;
    mem_ready = mr;
    opcode    = op;
    exp_q.push_back(model(st, mr, op));
  endtask

  // One instruction from fetch to retirement; optional reset abort in the memory wait.
  task automatic run_instr(logic [5:0] op, int wf, int wm, bit abort_mem);
    for (int i = 0; i < wf; i++) step(ST_FETCH, 0, 0, rop());
    step(ST_FETCH, 0, 1, rop());
    step(ST_DECODE, 0, rbit(), op);
    if (op == OP_LW || op == OP_SW) begin
      // Drive a misleading opcode here: the path must follow the latched one.
      step(ST_MEM_ADDR, 0, rbit(), (op == OP_SW) ? OP_J : OP_SW);
      for (int i = 0; i < wm; i++)
        step((op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE, 0, 0, rop());
      if (abort_mem) begin
        step((op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE, 1, 0, rop());
        step(ST_RST, 0, 1, rop());
      end else if (op == OP_LW) begin
        step(ST_MEM_READ, 0, 1, rop());
        step(ST_MEM_WB, 0, rbit(), rop());
      end else begin
        step(ST_MEM_WRITE, 0, 1, rop());
      end
    end else if (op == OP_RTYPE) begin
      step(ST_EXECUTE, 0, rbit(), rop());
      step(ST_R_WB, 0, rbit(), rop());
    end else if (op == OP_ADDI) begin
      step(ST_ADDI_EX, 0, rbit(), rop());
      step(ST_ADDI_WB, 0, rbit(), rop());
    end else if (op == OP_BEQ) begin
      step(ST_BRANCH, 0, rbit(), rop());
    end else if (op == OP_J) begin
      step(ST_JUMP, 0, rbit(), rop());
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {estado, pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source,
               instr_fim, illegal_op};
      checks++;
      if (mon_a === mon_e) passed++;
      else $display("FAIL ctrl_word cyc=%0d got=%h (estado %0d) expected=%h (estado %0d)",
                    cyc, mon_a, mon_a.st, mon_e, mon_e.st);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [5:0] op;
    int         k;
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = '0;
    step(ST_RST, 1, 1, 6'd0);
    step(ST_RST, 1, 1, 6'd0);
    step(ST_RST, 0, 1, 6'd0);

    run_instr(OP_LW,   0, 0, 0);
    run_instr(OP_SW,   0, 2, 0);
    run_instr(OP_BEQ,  0, 0, 0);
    run_instr(OP_J,    0, 0, 0);
    run_instr(OP_RTYPE,1, 0, 0);
    run_instr(OP_ADDI, 0, 0, 0);
    run_instr(6'b111111, 0, 0, 0);
    run_instr(OP_LW,   0, 1, 1);
    run_instr(OP_SW,   2, 1, 1);

    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 6);
      if (k < 6) op = legal_ops[k];
      else begin
        op = rop();
        while (is_legal(op)) op = rop();
      end
      run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
    end

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/controle_multiciclo_mips.md
# controle_multiciclo_mips

Multi-cycle control unit that sequences the shared MIPS datapath (single memory, single ALU, IR, PC) through fetch, decode, execute, memory and write-back steps. Moore FSM with a memory wait-state handshake. It replaces the single-cycle combinational control inside `Processador_MIPS` when the multi-cycle variant is built, and it drives every datapath mux and enable.

## Interface
- No parameters. Opcodes and state encodings are package constants.
- `clk`  in  1  system clock, rising-edge.
- `reset`  in  1  synchronous, active-high.
- `opcode`  in  6  IR[31:26]. Valid from the DECODE cycle onward.
- `mem_ready`  in  1  memory has completed the current read or write this cycle.
- `pc_write`  out  1  unconditional PC load.
- `pc_write_cond`  out  1  PC load if ALU zero (beq).
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `ir_write`  out  1  IR load.
- `mem_to_reg`  out  1  write-back data: 0 = ALUOut, 1 = MDR.
- `reg_dst`  out  1  destination register: 0 = rt, 1 = rd.
- `reg_write`  out  1  register file write.
- `alu_src_a`  out  1  ALU A input: 0 = PC, 1 = A.
- `alu_src_b`  out  2  ALU B input: 00 = B, 01 = const 4, 10 = signext imm, 11 = signext imm << 2.
- `alu_op`  out  2  00 = add, 01 = sub, 10 = use funct.
- `pc_source`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- `instr_fim`  out  1  one-cycle pulse in the last cycle of each retired instruction.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode.
- `estado`  out  4  current state, for debug and bench.

## Operation
- Supported opcodes: R = 000000, lw = 100011, sw = 101011, beq = 000100, j = 000010, addi = 001000.
- States:
  - RST
  - FETCH
  - DECODE
  - MEM_ADDR
  - MEM_READ
  - MEM_WB
  - MEM_WRITE
  - EXECUTE
  - R_WB
  - BRANCH
  - JUMP
  - ADDI_EX
  - ADDI_WB
- Transitions:
  - RST → FETCH.
  - FETCH → DECODE on `mem_ready`; otherwise stay in FETCH.
  - DECODE → MEM_ADDR for lw/sw, EXECUTE for R, BRANCH for beq, JUMP for j, ADDI_EX for addi, FETCH for any other opcode.
  - MEM_ADDR → MEM_READ for lw, MEM_WRITE for sw.
  - MEM_READ → MEM_WB on `mem_ready`; otherwise stay.
  - MEM_WRITE → FETCH on `mem_ready`; otherwise stay.
  - EXECUTE → R_WB; ADDI_EX → ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB → FETCH.
- `opcode` is latched into `op_q` in DECODE. MEM_ADDR decides lw vs sw from `op_q`, never from the live `opcode`.
- Outputs are decoded from the registered state. Every output not listed for a state is 0.
  - FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write` and `pc_write` equal `mem_ready`.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00.
  - MEM_ADDR and ADDI_EX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
  - MEM_READ: `mem_read`=1, `i_or_d`=1.
  - MEM_WRITE: `mem_write`=1, `i_or_d`=1.
  - MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
  - R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01.
  - JUMP: `pc_write`=1, `pc_source`=10.
- `instr_fim`=1 in MEM_WB, R_WB, ADDI_WB, BRANCH and JUMP, and in MEM_WRITE when `mem_ready`=1.
- `illegal_op`=1 in DECODE when the opcode is unsupported. `instr_fim` stays 0 for that instruction.

## Timing
- `reset` sampled high → next state RST, `op_q` = 0.
  - RST drives all outputs 0 and `estado` = RST encoding.
  - The first FETCH is the cycle after `reset` deasserts.
- Reset mid-instruction, including during a wait state, aborts immediately. No write strobe is asserted in the cycle after reset is sampled.
- Cycles per instruction with zero wait states:
  - R = 4, addi = 4
  - lw = 5, sw = 4
  - beq = 3, j = 3
  - Each wait cycle adds 1.
- `mem_ready` is ignored in states that do not strobe memory.
- `mem_read`/`mem_write` stay asserted and constant for the whole wait period.
- A glitch-free Moore decode is required. The only Mealy terms are:
  - `ir_write` and `pc_write` in FETCH;
  - `instr_fim` in MEM_WRITE.

## Structure
- Package `mips_ctrl_pkg` holds:
  - opcode localparams (`OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`);
  - 4-bit state encodings;
  - `alu_op`, `alu_src_b` and `pc_source` codes.
- Split into two parts:
  - the state register plus `op_q`;
  - an output decoder as one sub-module, `decod_saidas_ctrl`, which maps state and `mem_ready` to the control word.

## Test plan
- Reset held for 3 cycles, then released, with `mem_ready`=1: all outputs 0 during reset, RST for one cycle after release, then FETCH with `mem_read`=1, `ir_write`=1, `pc_write`=1.
- `opcode`=100011 (lw), `mem_ready`=1: state sequence FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB (5 cycles); `reg_write`=1 and `mem_to_reg`=1 only in MEM_WB; `instr_fim` pulses once.
- sw with `mem_ready` low for 2 cycles in MEM_WRITE: `mem_write`=1 and `i_or_d`=1 for 3 cycles, then FETCH; `instr_fim` only in the cycle with `mem_ready`=1.
- `opcode` changed to 000010 during MEM_ADDR of an sw: the path still goes to MEM_WRITE, because `op_q` holds the latched opcode.
- beq followed by j: BRANCH has `pc_write_cond`=1, `alu_op`=01, `pc_source`=01; JUMP has `pc_write`=1, `pc_source`=10; each takes 3 cycles.
- `opcode`=111111: DECODE pulses `illegal_op`, returns to FETCH, no `reg_write`/`mem_write`. Reset asserted in MEM_READ: next state RST, strobes 0.
